usb_ft_bus_arbiter: RTL and testbench
=====================================

USB_FT_BUS_ARBITER -- requirements
Module: usb_ft_bus_arbiter

Interface
REQ-001 Parameter RD_END_CYCLE_TIME, 25, last count of a read cycle.
REQ-002 Parameter RD_STROBE_START_TIME, 2, count at which FT_RDn asserts.
REQ-003 Parameter RD_STROBE_STOP_TIME, 12, count at which FT_RDn deasserts.
REQ-004 Parameter RD_SAMPLE_TIME, 9, count at which FT_DATA_In is captured.
REQ-005 Parameter WR_END_CYCLE_TIME, 25, last count of a write cycle.
REQ-006 Parameter WR_STROBE_START_TIME, 5, count at which FT_WR asserts.
REQ-007 Parameter WR_STROBE_STOP_TIME, 15, count at which FT_WR deasserts.
REQ-008 Parameter WR_ZZZ_START_TIME, 2, count at which FT_DATA_OE asserts.
REQ-009 Parameter WR_ZZZ_STOP_TIME, 22, count at which FT_DATA_OE deasserts.
REQ-010 Parameter GAP_TIME, 3, idle cycles after every bus cycle, covering the flag resync.
REQ-011 clk  in  1  single clock; all logic is on its rising edge.
REQ-012 clrn  in  1  asynchronous active-low reset.
REQ-013 FT_RXFn  in  1  FT245 "RX data available", active low, asynchronous.
REQ-014 FT_TXEn  in  1  FT245 "TX space available", active low, asynchronous.
REQ-015 FT_DATA_In  in  8  FT245 data bus, input side.
REQ-016 FT_RDn  out  1  FT245 read strobe, active low.
REQ-017 FT_WR  out  1  FT245 write strobe, active high.
REQ-018 FT_DATA_Out  out  8  FT245 data bus, output side.
REQ-019 FT_DATA_OE  out  1  drive enable for the FT245 data bus.
REQ-020 rx_hold  in  1  consumer back-pressure; blocks the start of new reads.
REQ-021 rx_valid  out  1  one-cycle pulse: rx_data is valid.
REQ-022 rx_data  out  8  received byte, held until the next capture.
REQ-023 tx_valid  in  1  producer has a byte on tx_data.
REQ-024 tx_data  in  8  byte to transmit.
REQ-025 tx_ready  out  1  one-cycle pulse: tx_data accepted this cycle.

Function
REQ-026 FT_RXFn and FT_TXEn SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (rxf_s, txe_s).
REQ-027 The FSM SHALL have states IDLE, RD, WR and GAP; the cycle counter is 8 bits, cleared on every state entry, and increments in RD, WR and GAP.
REQ-028 The read request is rd_req = ~rxf_s & ~rx_hold; the write request is wr_req = ~txe_s & tx_valid; arbitration occurs only in IDLE.
REQ-029 On a grant to WR in IDLE, tx_ready SHALL pulse in that same cycle, tx_data SHALL be latched into FT_DATA_Out, and the FSM SHALL enter WR.
REQ-030 In RD: FT_RDn is low for count in [RD_STROBE_START_TIME, RD_STROBE_STOP_TIME); FT_DATA_In is captured into rx_data at count == RD_SAMPLE_TIME; rx_valid pulses on the following cycle.
REQ-031 In WR: FT_DATA_OE is high for count in [WR_ZZZ_START_TIME, WR_ZZZ_STOP_TIME); FT_WR is high for count in [WR_STROBE_START_TIME, WR_STROBE_STOP_TIME).
REQ-032 Transitions: RD exits at count == RD_END_CYCLE_TIME and WR exits at count == WR_END_CYCLE_TIME, both to GAP; GAP exits to IDLE at count == GAP_TIME-1.
REQ-033 If rd_req and wr_req are both true in IDLE, the winner SHALL be decided per REQ-040/041; if neither is true, the FSM SHALL stay in IDLE.
REQ-034 Once a cycle has started, changes on rx_hold, tx_valid, FT_RXFn or FT_TXEn SHALL NOT abort it.
REQ-035 FT_RDn low and FT_DATA_OE high SHALL never occur in the same cycle.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 When clrn is low: state = IDLE, counter = 0, synchronizers = 1, FT_RDn = 1, FT_WR = 0, FT_DATA_OE = 0, FT_DATA_Out = 0, rx_valid = 0, rx_data = 0, tx_ready = 0, last_grant = WR.
REQ-038 Reset asserted mid-cycle SHALL release the bus immediately (asynchronously); after release the block SHALL start from IDLE, with no resumed or partial cycle.

Configuration
REQ-039 Macro USB_FT_FAIRNESS_EN selects the arbitration policy.
REQ-040 With USB_FT_FAIRNESS_EN defined: round-robin; on a tie the side not equal to last_grant wins; last_grant updates on every grant.
REQ-041 Without USB_FT_FAIRNESS_EN: fixed priority, RD always wins a tie; last_grant is unused.

Verification
REQ-042 RXFn low, rx_hold = 0, FT_DATA_In = 8'hA5 -> FT_RDn low for 10 clocks; rx_valid pulses once with rx_data = 8'hA5.
REQ-043 TXEn low, tx_valid with tx_data = 8'h3C -> one tx_ready pulse; FT_WR high for 10 clocks; FT_DATA_Out = 8'h3C while FT_DATA_OE is high (20 clocks).
REQ-044 Both requests held continuously, USB_FT_FAIRNESS_EN defined -> grant sequence RD, WR, RD, WR; without the macro -> RD, RD, RD, RD.
REQ-045 rx_hold = 1 with RXFn low and no TX request -> FT_RDn stays high and the FSM remains in IDLE; deasserting rx_hold -> a read starts within 4 clocks.
REQ-046 clrn pulsed low at WR count 10 -> FT_WR = 0 and FT_DATA_OE = 0 immediately; no tx_ready pulse until the next grant.

Source files
------------

// File: rtl/usb_ft_bus_arbiter.sv
// FT245 FIFO bus arbiter: time-sliced read/write cycles on a shared FT245 bus.
// Define USB_FT_FAIRNESS_EN for round-robin arbitration; default is read-priority.
module usb_ft_bus_arbiter #(
   parameter int unsigned RD_END_CYCLE_TIME    = 25,
   parameter int unsigned RD_STROBE_START_TIME = 2,
   parameter int unsigned RD_STROBE_STOP_TIME  = 12,
   parameter int unsigned RD_SAMPLE_TIME       = 9,
   parameter int unsigned WR_END_CYCLE_TIME    = 25,
   parameter int unsigned WR_STROBE_START_TIME = 5,
   parameter int unsigned WR_STROBE_STOP_TIME  = 15,
   parameter int unsigned WR_ZZZ_START_TIME    = 2,
   parameter int unsigned WR_ZZZ_STOP_TIME     = 22,
   parameter int unsigned GAP_TIME             = 3
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       FT_RXFn,
   input  logic       FT_TXEn,
   input  logic [7:0] FT_DATA_In,
   output logic       FT_RDn,
   output logic       FT_WR,
   output logic [7:0] FT_DATA_Out,
   output logic       FT_DATA_OE,
   input  logic       rx_hold,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready
);

   localparam logic [7:0] RdEnd     = 8'(RD_END_CYCLE_TIME);
   localparam logic [7:0] RdStart   = 8'(RD_STROBE_START_TIME);
   localparam logic [7:0] RdStop    = 8'(RD_STROBE_STOP_TIME);
   localparam logic [7:0] RdSample  = 8'(RD_SAMPLE_TIME);
   localparam logic [7:0] WrEnd     = 8'(WR_END_CYCLE_TIME);
   localparam logic [7:0] WrStart   = 8'(WR_STROBE_START_TIME);
   localparam logic [7:0] WrStop    = 8'(WR_STROBE_STOP_TIME);
   localparam logic [7:0] OeStart   = 8'(WR_ZZZ_START_TIME);
   localparam logic [7:0] OeStop    = 8'(WR_ZZZ_STOP_TIME);
   localparam logic [7:0] GapLast   = 8'(GAP_TIME - 1);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StGap} state_e;

   state_e     state_q;
   logic [7:0] cnt_q;
   logic [7:0] cnt_inc;
   logic       rxf_meta, rxf_s, txe_meta, txe_s;
   logic       rd_req, wr_req, grant_rd, grant_wr;
`ifdef USB_FT_FAIRNESS_EN
   logic       last_grant_wr;
`endif

   function automatic logic in_win(input logic [7:0] c, input logic [7:0] lo,
                                   input logic [7:0] hi);
      return (c >= lo) && (c < hi);
   endfunction

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rxf_meta <= 1'b1;
         rxf_s    <= 1'b1;
         txe_meta <= 1'b1;
         txe_s    <= 1'b1;
      end else begin
         rxf_meta <= FT_RXFn;
         rxf_s    <= rxf_meta;
         txe_meta <= FT_TXEn;
         txe_s    <= txe_meta;
      end
   end

   always_comb begin
      rd_req  = ~rxf_s & ~rx_hold;
      wr_req  = ~txe_s & tx_valid;
`ifdef USB_FT_FAIRNESS_EN
      grant_rd = rd_req & (~wr_req | last_grant_wr);
`else
      grant_rd = rd_req;
`endif
      grant_wr = wr_req & ~grant_rd;
      cnt_inc  = cnt_q + 8'd1;
   end

   // Strobe outputs are computed from the next count so they line up with cnt_q.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         FT_RDn      <= 1'b1;
         FT_WR       <= 1'b0;
         FT_DATA_OE  <= 1'b0;
         FT_DATA_Out <= '0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         tx_ready    <= 1'b0;
`ifdef USB_FT_FAIRNESS_EN
         last_grant_wr <= 1'b1;
`endif
      end else begin
         rx_valid   <= 1'b0;
         tx_ready   <= 1'b0;
         FT_RDn     <= 1'b1;
         FT_WR      <= 1'b0;
         FT_DATA_OE <= 1'b0;
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (grant_rd) begin
                  state_q <= StRd;
                  FT_RDn  <= ~in_win(8'd0, RdStart, RdStop);
`ifdef USB_FT_FAIRNESS_EN
                  last_grant_wr <= 1'b0;
`endif
               end else if (grant_wr) begin
                  state_q     <= StWr;
                  tx_ready    <= 1'b1;
                  FT_DATA_Out <= tx_data;
                  FT_WR       <= in_win(8'd0, WrStart, WrStop);
                  FT_DATA_OE  <= in_win(8'd0, OeStart, OeStop);
`ifdef USB_FT_FAIRNESS_EN
                  last_grant_wr <= 1'b1;
`endif
               end
            end
            StRd: begin
               if (cnt_q == RdSample) begin
                  rx_data  <= FT_DATA_In;
                  rx_valid <= 1'b1;
               end
               if (cnt_q == RdEnd) begin
                  state_q <= StGap;
                  cnt_q   <= '0;
               end else begin
                  cnt_q  <= cnt_inc;
                  FT_RDn <= ~in_win(cnt_inc, RdStart, RdStop);
               end
            end
            StWr: begin
               if (cnt_q == WrEnd) begin
                  state_q <= StGap;
                  cnt_q   <= '0;
               end else begin
                  cnt_q      <= cnt_inc;
                  FT_WR      <= in_win(cnt_inc, WrStart, WrStop);
                  FT_DATA_OE <= in_win(cnt_inc, OeStart, OeStop);
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_ft_bus_arbiter.sv
// Directed self-checking bench for usb_ft_bus_arbiter (default timing parameters).
module tb_usb_ft_bus_arbiter;

   logic       clk;
   logic       clrn;
   logic       FT_RXFn, FT_TXEn;
   logic [7:0] FT_DATA_In;
   logic       FT_RDn, FT_WR, FT_DATA_OE;
   logic [7:0] FT_DATA_Out;
   logic       rx_hold, rx_valid, tx_valid, tx_ready;
   logic [7:0] rx_data, tx_data;

   int n_vec  = 0;
   int n_miss = 0;

   usb_ft_bus_arbiter dut (
      .clk        (clk),
      .clrn       (clrn),
      .FT_RXFn    (FT_RXFn),
      .FT_TXEn    (FT_TXEn),
      .FT_DATA_In (FT_DATA_In),
      .FT_RDn     (FT_RDn),
      .FT_WR      (FT_WR),
      .FT_DATA_Out(FT_DATA_Out),
      .FT_DATA_OE (FT_DATA_OE),
      .rx_hold    (rx_hold),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rd_low, rv, first_low, rv_at, overlap, got_data;
      int wr_hi, oe_hi, wr_first, bad_data, rdy, ng, prev_rdn, hi_cnt, lat, act;
      int got_g[4];
      int exp_g[4];

      clrn = 1'b0; FT_RXFn = 1'b1; FT_TXEn = 1'b1; FT_DATA_In = 8'h00;
      rx_hold = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      tick(); tick();
      check("rst_rdn", 32'(FT_RDn), 1);
      check("rst_wr", 32'(FT_WR), 0);
      check("rst_oe", 32'(FT_DATA_OE), 0);
      check("rst_dout", 32'(FT_DATA_Out), 0);
      check("rst_rxv", 32'(rx_valid), 0);
      check("rst_rxd", 32'(rx_data), 0);
      check("rst_txr", 32'(tx_ready), 0);
      clrn = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("idle_rdn", 32'(FT_RDn), 1);

      // Single read cycle
      FT_DATA_In = 8'hA5; FT_RXFn = 1'b0;
      rd_low = 0; rv = 0; first_low = -1; rv_at = -1; overlap = 0; got_data = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (!FT_RDn) begin
            rd_low++;
            if (first_low < 0) first_low = i;
         end
         if (rx_valid) begin rv++; rv_at = i; got_data = 32'(rx_data); end
         if (!FT_RDn && FT_DATA_OE) overlap++;
         if (i == 6) FT_RXFn = 1'b1;
         if (rx_valid) FT_DATA_In = 8'h5A;
      end
      check("rd_low_len", rd_low, 10);
      check("rd_first_low", first_low, 5);
      check("rd_valid_cnt", rv, 1);
      check("rd_valid_at", rv_at, 13);
      check("rd_data", got_data, 32'hA5);
      check("rd_data_held", 32'(rx_data), 32'hA5);
      check("rd_overlap", overlap, 0);

      // Single write cycle
      FT_TXEn = 1'b0; tx_valid = 1'b1; tx_data = 8'h3C;
      wr_hi = 0; oe_hi = 0; wr_first = -1; bad_data = 0; rdy = 0; overlap = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (tx_ready) begin
            rdy++;
            tx_valid = 1'b0; tx_data = 8'hFF; FT_TXEn = 1'b1;
         end
         if (FT_WR) begin
            wr_hi++;
            if (wr_first < 0) wr_first = i;
            if (!FT_DATA_OE) bad_data++;
         end
         if (FT_DATA_OE) begin
            oe_hi++;
            if (FT_DATA_Out != 8'h3C) bad_data++;
         end
         if (!FT_RDn) overlap++;
      end
      check("wr_ready_cnt", rdy, 1);
      check("wr_strobe_len", wr_hi, 10);
      check("wr_first_hi", wr_first, 8);
      check("wr_oe_len", oe_hi, 20);
      check("wr_bus_data", bad_data, 0);
      check("wr_no_read", overlap, 0);

      // Both requesters held continuously
`ifdef USB_FT_FAIRNESS_EN
      exp_g = '{1, 2, 1, 2};
`else
      exp_g = '{1, 1, 1, 1};
`endif
      got_g = '{0, 0, 0, 0};
      FT_RXFn = 1'b0; FT_TXEn = 1'b0; tx_valid = 1'b1; tx_data = 8'h11;
      ng = 0; prev_rdn = 1; overlap = 0;
      for (int i = 0; i < 200 && ng < 4; i++) begin
         tick();
         if (prev_rdn == 1 && !FT_RDn) begin got_g[ng] = 1; ng++; end
         else if (tx_ready) begin got_g[ng] = 2; ng++; end
         if (!FT_RDn && FT_DATA_OE) overlap++;
         prev_rdn = 32'(FT_RDn);
      end
      FT_RXFn = 1'b1; FT_TXEn = 1'b1; tx_valid = 1'b0;
      check("tie_grants", ng, 4);
      for (int k = 0; k < 4; k++) check($sformatf("tie_grant%0d", k), got_g[k], exp_g[k]);
      check("tie_overlap", overlap, 0);
      for (int i = 0; i < 40; i++) tick();

      // Consumer back-pressure
      rx_hold = 1'b1; FT_RXFn = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (FT_RDn && !FT_WR && !FT_DATA_OE && !tx_ready) hi_cnt++;
      end
      check("hold_idle", hi_cnt, 12);
      rx_hold = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         tick();
         if (!FT_RDn) lat = i;
      end
      check("hold_release_lat", lat, 3);
      FT_RXFn = 1'b1;
      for (int i = 0; i < 40; i++) tick();

      // Reset in the middle of a write
      FT_TXEn = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         tick();
         if (tx_ready) lat = i;
      end
      check("mid_ready_lat", lat, 3);
      tx_valid = 1'b0; FT_TXEn = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("mid_wr_hi", 32'(FT_WR), 1);
      check("mid_oe_hi", 32'(FT_DATA_OE), 1);
      check("mid_dout", 32'(FT_DATA_Out), 32'hC3);
      #2 clrn = 1'b0;
      #1;
      check("async_wr", 32'(FT_WR), 0);
      check("async_oe", 32'(FT_DATA_OE), 0);
      check("async_dout", 32'(FT_DATA_Out), 0);
      tick(); tick();
      clrn = 1'b1;
      act = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_ready || FT_WR || FT_DATA_OE || !FT_RDn) act++;
      end
      check("post_rst_quiet", act, 0);
      FT_TXEn = 1'b0; tx_valid = 1'b1; tx_data = 8'h96;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         tick();
         if (tx_ready) lat = i;
      end
      check("regrant_lat", lat, 3);
      check("regrant_dout", 32'(FT_DATA_Out), 32'h96);
      tx_valid = 1'b0; FT_TXEn = 1'b1;
      for (int i = 0; i < 35; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
